// File: rtl/dmem_wb_bridge_if.sv
// Bus bundles for the dmem-to-Wishbone bridge: the core-side dmem request
// interface and the Wishbone B4 classic bus (dat_w = master->slave, dat_r = slave->master).

interface dmem_if;
    logic        rd;
    logic        wr;
    logic [3:0]  strobe;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        ready;
    logic        err;

    modport master (
        output rd, wr, strobe, addr, wdata,
        input  rdata, rdata_valid, ready, err
    );

    modport slave (
        input  rd, wr, strobe, addr, wdata,
        output rdata, rdata_valid, ready, err
    );
endinterface

interface wb_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;
    logic        err;

    modport master (
        output cyc, stb, we, adr, sel, dat_w,
        input  dat_r, ack, err
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_w,
        output dat_r, ack, err
    );
endinterface

// File: rtl/dmem_wb_bridge.sv
// Bridges single core dmem requests onto a Wishbone B4 classic bus, one transaction
// at a time, with a bus timeout so a silent slave cannot stall the core forever.

module dmem_wb_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    dmem_if.slave dmem,
    wb_if.master  wb
);

    localparam int unsigned     CNT_W     = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_e;

    state_e           state_q, state_d;
    logic             cyc_q, cyc_d;
    logic             we_q, we_d;
    logic [31:0]      adr_q, adr_d;
    logic [3:0]       sel_q, sel_d;
    logic [31:0]      dat_q, dat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rdata_valid_q, rdata_valid_d;
    logic             err_q, err_d;

    logic timeout;
    logic unused_addr_bits;

    // The low address bits select bytes via strobe and never reach the bus.
    assign unused_addr_bits = ^dmem.addr[1:0];

    assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LIMIT);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d       = state_q;
        cyc_d         = cyc_q;
        we_d          = we_q;
        adr_d         = adr_q;
        sel_d         = sel_q;
        dat_d         = dat_q;
        cnt_d         = cnt_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        err_d         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (dmem.rd && dmem.wr) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end else if (dmem.rd ^ dmem.wr) begin
                    we_d  = dmem.wr;
                    adr_d = {dmem.addr[31:2], 2'b00};
                    sel_d = dmem.wr ? dmem.strobe : 4'hF;
                    dat_d = dmem.wdata;
                    cnt_d = CNT_ONE;
                    // A write that touches no bytes completes without a bus cycle.
                    if (dmem.wr && (dmem.strobe == 4'h0)) begin
                        state_d = RESP;
                    end else begin
                        state_d = BUS;
                        cyc_d   = 1'b1;
                    end
                end
            end

            BUS: begin
                if (wb.err || wb.ack || timeout) begin
                    state_d       = RESP;
                    cyc_d         = 1'b0;
                    // err beats ack; reaching here without ack means a timeout.
                    err_d         = wb.err || !wb.ack;
                    rdata_valid_d = !we_q;
                    if (!we_q) begin
                        rdata_d = (wb.ack && !wb.err) ? wb.dat_r : ERR_RDATA;
                    end
                end else if (TIMEOUT_CYCLES != 0) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    // NOTE: state is updated only with non-blocking assignments so every flop
    // samples the values computed for this edge, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            cyc_q         <= 1'b0;
            we_q          <= 1'b0;
            adr_q         <= '0;
            sel_q         <= '0;
            dat_q         <= '0;
            cnt_q         <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cyc_q         <= cyc_d;
            we_q          <= we_d;
            adr_q         <= adr_d;
            sel_q         <= sel_d;
            dat_q         <= dat_d;
            cnt_q         <= cnt_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            err_q         <= err_d;
        end
    end

    assign wb.cyc   = cyc_q;
    assign wb.stb   = cyc_q;
    assign wb.we    = we_q;
    assign wb.adr   = adr_q;
    assign wb.sel   = sel_q;
    assign wb.dat_w = dat_q;

    assign dmem.ready       = (state_q == IDLE);
    assign dmem.rdata       = rdata_q;
    assign dmem.rdata_valid = rdata_valid_q;
    assign dmem.err         = err_q;

endmodule

// File: tb/tb_dmem_wb_bridge.sv
// Bench for dmem_wb_bridge: a transaction-level model predicts every output per cycle,
// a negedge process compares, and directed cases pin the model with literal values.

module tb_dmem_wb_bridge;

    localparam int          TO    = 4;
    localparam logic [31:0] ERR_D = 32'hDEAD_BEEF;

    localparam int K_RD  = 0;
    localparam int K_WR  = 1;
    localparam int K_ILL = 2;

    localparam int R_ACK  = 0;
    localparam int R_ERR  = 1;
    localparam int R_BOTH = 2;
    localparam int R_NONE = 3;

    logic clk;
    logic rst_n;

    dmem_if d_if ();
    wb_if   w_if ();

    dmem_wb_bridge #(
        .TIMEOUT_CYCLES (TO),
        .ERR_RDATA      (ERR_D)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .dmem   (d_if),
        .wb     (w_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model expectations for the current cycle.
    logic        chk_en = 1'b0;
    logic        exp_ready, exp_cyc, exp_we, exp_rv, exp_err;
    logic [31:0] exp_adr, exp_dat, exp_rdata;
    logic [3:0]  exp_sel;

    // Observations of the last transaction for directed literal checks.
    int          cap_cyc_cycles;
    logic        cap_rv, cap_err, cap_ready;
    logic [31:0] cap_adr, cap_rdata;
    logic [3:0]  cap_sel;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", {31'd0, d_if.ready}, {31'd0, exp_ready});
            check("cyc", {31'd0, w_if.cyc}, {31'd0, exp_cyc});
            check("stb", {31'd0, w_if.stb}, {31'd0, exp_cyc});
            check("rdata_valid", {31'd0, d_if.rdata_valid}, {31'd0, exp_rv});
            check("dmem_err", {31'd0, d_if.err}, {31'd0, exp_err});
            check("rdata", d_if.rdata, exp_rdata);
            if (exp_cyc) begin
                check("we", {31'd0, w_if.we}, {31'd0, exp_we});
                check("adr", w_if.adr, exp_adr);
                check("sel", {28'd0, w_if.sel}, {28'd0, exp_sel});
                check("dat_o", w_if.dat_w, exp_dat);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        #3;
        if (w_if.cyc) begin
            cap_cyc_cycles++;
            cap_adr = w_if.adr;
            cap_sel = w_if.sel;
        end
        cap_rv    = cap_rv | d_if.rdata_valid;
        cap_err   = cap_err | d_if.err;
        cap_rdata = d_if.rdata;
    endtask

    task automatic junk_slave();
        w_if.ack   = ($urandom_range(0, 3) == 0);
        w_if.err   = ($urandom_range(0, 3) == 0);
        w_if.dat_r = $urandom;
    endtask

    task automatic junk_core();
        d_if.rd     = $urandom_range(0, 1) == 1;
        d_if.wr     = $urandom_range(0, 1) == 1;
        d_if.strobe = 4'($urandom);
        d_if.addr   = $urandom;
        d_if.wdata  = $urandom;
    endtask

    task automatic set_exp_quiet(input logic ready);
        exp_ready = ready;
        exp_cyc   = 1'b0;
        exp_rv    = 1'b0;
        exp_err   = 1'b0;
    endtask

    task automatic idle_cycle();
        junk_core();
        d_if.rd = 1'b0;
        d_if.wr = 1'b0;
        junk_slave();
        set_exp_quiet(1'b1);
        step();
    endtask

    task automatic do_txn(input int kind, input logic [31:0] addr, input logic [3:0] strb,
                          input logic [31:0] wdata, input int wait_n, input int resp,
                          input logic [31:0] rsp_dat);
        logic is_rd;
        logic timed_out;
        int   n;
        is_rd          = (kind == K_RD);
        cap_cyc_cycles = 0;
        cap_rv         = 1'b0;
        cap_err        = 1'b0;

        d_if.rd     = (kind != K_WR);
        d_if.wr     = (kind != K_RD);
        d_if.strobe = strb;
        d_if.addr   = addr;
        d_if.wdata  = wdata;
        junk_slave();
        set_exp_quiet(1'b1);
        sample();
        step();

        if (kind == K_ILL || (kind == K_WR && strb == 4'h0)) begin
            junk_core();
            junk_slave();
            set_exp_quiet(1'b0);
            exp_err = (kind == K_ILL);
            sample();
            step();
            cap_ready = d_if.ready;
            return;
        end

        timed_out = (resp == R_NONE) || (wait_n + 1 > TO);
        n         = timed_out ? TO : wait_n + 1;
        exp_ready = 1'b0;
        exp_cyc   = 1'b1;
        exp_rv    = 1'b0;
        exp_err   = 1'b0;
        exp_we    = !is_rd;
        exp_adr   = {addr[31:2], 2'b00};
        exp_sel   = is_rd ? 4'hF : strb;
        exp_dat   = wdata;
        for (int b = 1; b <= n; b++) begin
            junk_core();
            w_if.ack   = 1'b0;
            w_if.err   = 1'b0;
            w_if.dat_r = $urandom;
            if (b == n && !timed_out) begin
                w_if.ack   = (resp != R_ERR);
                w_if.err   = (resp != R_ACK);
                w_if.dat_r = rsp_dat;
            end
            sample();
            step();
        end

        junk_core();
        junk_slave();
        exp_ready = 1'b0;
        exp_cyc   = 1'b0;
        exp_rv    = is_rd;
        exp_err   = timed_out || (resp != R_ACK);
        if (is_rd) exp_rdata = (!timed_out && resp == R_ACK) ? rsp_dat : ERR_D;
        sample();
        step();
        cap_ready = d_if.ready;
    endtask

    initial begin
        rst_n       = 1'b0;
        d_if.rd     = 1'b0;
        d_if.wr     = 1'b0;
        d_if.strobe = 4'h0;
        d_if.addr   = 32'h0;
        d_if.wdata  = 32'h0;
        w_if.ack    = 1'b0;
        w_if.err    = 1'b0;
        w_if.dat_r  = 32'h0;
        exp_rdata   = 32'h0;
        exp_we      = 1'b0;
        exp_adr     = 32'h0;
        exp_sel     = 4'h0;
        exp_dat     = 32'h0;
        set_exp_quiet(1'b1);

        #3;
        check("rst cyc", {31'd0, w_if.cyc}, 32'd0);
        check("rst stb", {31'd0, w_if.stb}, 32'd0);
        check("rst we", {31'd0, w_if.we}, 32'd0);
        check("rst adr", w_if.adr, 32'd0);
        check("rst sel", {28'd0, w_if.sel}, 32'd0);
        check("rst dat_o", w_if.dat_w, 32'd0);
        check("rst rdata", d_if.rdata, 32'd0);
        check("rst rdata_valid", {31'd0, d_if.rdata_valid}, 32'd0);
        check("rst err", {31'd0, d_if.err}, 32'd0);
        #9 rst_n = 1'b1;
        step();
        check("ready after reset", {31'd0, d_if.ready}, 32'd1);
        chk_en = 1'b1;

        // Read acked on first strobe cycle.
        do_txn(K_RD, 32'h0000_1003, 4'h0, 32'h5555_AAAA, 0, R_ACK, 32'hCAFE_F00D);
        check("t1 adr", cap_adr, 32'h0000_1000);
        check("t1 sel", {28'd0, cap_sel}, 32'h0000_000F);
        check("t1 rv", {31'd0, cap_rv}, 32'd1);
        check("t1 rdata", cap_rdata, 32'hCAFE_F00D);
        check("t1 ready", {31'd0, cap_ready}, 32'd1);

        // Write after three wait cycles; ack lands on the timeout limit and must win.
        do_txn(K_WR, 32'h0000_2000, 4'b0110, 32'h1234_5678, 3, R_ACK, 32'h0);
        check("t2 stb cycles", cap_cyc_cycles, 32'd4);
        check("t2 sel", {28'd0, cap_sel}, 32'h0000_0006);
        check("t2 rv", {31'd0, cap_rv}, 32'd0);
        check("t2 err", {31'd0, cap_err}, 32'd0);
        check("t2 ready", {31'd0, cap_ready}, 32'd1);

        // Read to a silent slave times out.
        do_txn(K_RD, 32'h0000_3004, 4'h0, 32'h0, 0, R_NONE, 32'h0);
        check("t3 stb cycles", cap_cyc_cycles, 32'd4);
        check("t3 err", {31'd0, cap_err}, 32'd1);
        check("t3 rv", {31'd0, cap_rv}, 32'd1);
        check("t3 rdata", cap_rdata, 32'hDEAD_BEEF);

        // err and ack together: err wins.
        do_txn(K_RD, 32'h0000_4008, 4'h0, 32'h0, 1, R_BOTH, 32'h1111_2222);
        check("t4 err", {31'd0, cap_err}, 32'd1);
        check("t4 rdata", cap_rdata, 32'hDEAD_BEEF);

        // Illegal rd & wr.
        do_txn(K_ILL, 32'h0000_5000, 4'hF, 32'h0, 0, R_ACK, 32'h0);
        check("t5 cyc cycles", cap_cyc_cycles, 32'd0);
        check("t5 err", {31'd0, cap_err}, 32'd1);
        check("t5 rv", {31'd0, cap_rv}, 32'd0);
        check("t5 ready", {31'd0, cap_ready}, 32'd1);

        // Write with no byte enables.
        do_txn(K_WR, 32'h0000_6000, 4'h0, 32'hFFFF_0000, 0, R_ACK, 32'h0);
        check("t7 cyc cycles", cap_cyc_cycles, 32'd0);
        check("t7 err", {31'd0, cap_err}, 32'd0);
        check("t7 ready", {31'd0, cap_ready}, 32'd1);

        // Reset while the strobe is high.
        d_if.rd     = 1'b1;
        d_if.wr     = 1'b0;
        d_if.addr   = 32'h0000_7000;
        d_if.wdata  = 32'h0;
        w_if.ack    = 1'b0;
        w_if.err    = 1'b0;
        set_exp_quiet(1'b1);
        step();
        d_if.rd   = 1'b0;
        exp_ready = 1'b0;
        exp_cyc   = 1'b1;
        exp_we    = 1'b0;
        exp_adr   = 32'h0000_7000;
        exp_sel   = 4'hF;
        exp_dat   = 32'h0;
        step();
        chk_en = 1'b0;
        check("pre-reset stb", {31'd0, w_if.stb}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async rst cyc", {31'd0, w_if.cyc}, 32'd0);
        check("async rst stb", {31'd0, w_if.stb}, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        exp_rdata = 32'h0;
        set_exp_quiet(1'b1);
        step();
        chk_en = 1'b1;
        check("ready after mid reset", {31'd0, d_if.ready}, 32'd1);
        for (int i = 0; i < 3; i++) idle_cycle();

        // Randomized traffic.
        for (int t = 0; t < 300; t++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                idle_cycle();
            end else if (sel == 1) begin
                do_txn(K_ILL, $urandom, 4'($urandom), $urandom, 0, R_ACK, $urandom);
            end else begin
                do_txn((sel < 6) ? K_RD : K_WR, $urandom, 4'($urandom), $urandom,
                       $urandom_range(0, 5), $urandom_range(0, 3), $urandom);
            end
        end
        idle_cycle();
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
